alu_z_stage: RTL and testbench

- Result-capture stage directly downstream of the combinational ALU.
- Sequences each ALU operation: holds the op for its latency, then captures the 64-bit ALU result into Z (z_hi/z_lo).
- Flags multiply/divide results for HI/LO writeback; derives zero/negative/divide-by-zero/illegal-op status.
- Offers a ready/valid/ack handshake to the control unit.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/op_latency_counter.sv | 27 ++
 rtl/alu_z_stage.sv | 135 +++++++++++++
 tb/tb_alu_z_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, stage states and latency classes.
// Opcode values mirror the combinational ALU's encoding exactly.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        LAT_SINGLE,
        LAT_MUL,
        LAT_DIV
    } lat_class_e;

    function automatic logic is_legal_opcode(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
            OP_ROL, OP_MUL, OP_DIV, OP_NEG,
            OP_NOT:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic lat_class_e latency_class(input logic [4:0] op);
        case (op)
            OP_MUL:  return LAT_MUL;
            OP_DIV:  return LAT_DIV;
            default: return LAT_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/op_latency_counter.sv
// Down-counter timing a multi-cycle op; saturates at zero until reloaded.
module op_latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/alu_z_stage.sv
// ALU result-capture stage: times each op, latches Z and status flags,
// and hands the result to the control unit over ready/valid/ack.
module alu_z_stage
    import alu_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] b_operand,
    input  logic [63:0] alu_result,
    input  logic        ack,
    output logic        ready,
    output logic        busy,
    output logic        valid,
    output logic        done,
    output logic        hilo_we,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        zero,
    output logic        negative,
    output logic        div_zero,
    output logic        illegal_op
);

    localparam int MAX_A = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int MAX_L = (MAX_A > ALU_LATENCY) ? MAX_A : ALU_LATENCY;
    localparam int CW    = (MAX_L > 1) ? $clog2(MAX_L) : 1;

    state_e     state;
    state_e     state_nx;
    lat_class_e cls_in;
    lat_class_e cls_q;
    logic [4:0]    op_q;
    logic [CW-1:0] load_val;
    logic [63:0]   cap_val;
    logic accept;
    logic cap;
    logic cnt_exp;
    logic ill_in;
    logic dz_in;
    logic sel_ovr;
    logic sel_mul;
    logic sel_div;

    assign ready  = (state == ST_IDLE) || (state == ST_HOLD && ack);
    assign busy   = (state == ST_EXEC);
    assign valid  = (state == ST_HOLD);
    assign accept = start && ready;
    assign cap    = busy && cnt_exp;

    assign cls_in = latency_class(opcode);
    assign cls_q  = latency_class(op_q);
    assign ill_in = !is_legal_opcode(opcode);
    assign dz_in  = (cls_in == LAT_DIV) && (b_operand == '0);

    assign sel_ovr = ill_in || dz_in;
    assign sel_mul = (cls_in == LAT_MUL);
    assign sel_div = (cls_in == LAT_DIV) && !dz_in;

    // Faulted ops finish in one cycle and always produce a zero result
    assign cap_val = (div_zero || illegal_op) ? '0 : alu_result;

    always_comb begin
        load_val = CW'(ALU_LATENCY - 1);
        unique case (1'b1)
            sel_ovr: load_val = '0;
            sel_mul: load_val = CW'(MUL_LATENCY - 1);
            sel_div: load_val = CW'(DIV_LATENCY - 1);
            default: load_val = CW'(ALU_LATENCY - 1);
        endcase
    end

    op_latency_counter #(
        .W(CW)
    ) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (accept),
        .load_val (load_val),
        .dec      (busy),
        .expired  (cnt_exp)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_EXEC;
            ST_EXEC: if (cnt_exp) state_nx = ST_HOLD;
            ST_HOLD: if (ack) state_nx = start ? ST_EXEC : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q       <= '0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
            done       <= 1'b0;
            hilo_we    <= 1'b0;
            z_hi       <= '0;
            z_lo       <= '0;
            zero       <= 1'b0;
            negative   <= 1'b0;
        end else begin
            done    <= cap;
            hilo_we <= cap && (cls_q == LAT_MUL || cls_q == LAT_DIV);
            if (accept) begin
                op_q       <= opcode;
                div_zero   <= dz_in;
                illegal_op <= ill_in;
            end
            if (cap) begin
                z_hi     <= cap_val[63:32];
                z_lo     <= cap_val[31:0];
                zero     <= (cap_val == '0);
                negative <= (cls_q == LAT_MUL) ? cap_val[63] : cap_val[31];
            end
        end
    end

endmodule

// File: tb/tb_alu_z_stage.sv
// Self-checking bench for alu_z_stage against a spec-level reference model.
module tb_alu_z_stage;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam int ALU_LAT = 1;

    logic        clk;
    logic        clr;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] b_operand;
    logic [63:0] alu_result;
    logic        ack;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        done;
    logic        hilo_we;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        zero;
    logic        negative;
    logic        div_zero;
    logic        illegal_op;

    int passed;
    int total;

    alu_z_stage #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT),
        .ALU_LATENCY (ALU_LAT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .opcode     (opcode),
        .b_operand  (b_operand),
        .alu_result (alu_result),
        .ack        (ack),
        .ready      (ready),
        .busy       (busy),
        .valid      (valid),
        .done       (done),
        .hilo_we    (hilo_we),
        .z_hi       (z_hi),
        .z_lo       (z_lo),
        .zero       (zero),
        .negative   (negative),
        .div_zero   (div_zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [4:0] legal_ops [13] = '{
        5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
        5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
        5'b10000, 5'b10001, 5'b10010
    };

    function automatic bit m_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_dz(input logic [4:0] op, input logic [31:0] b);
        return (op == 5'b10000) && (b == 0);
    endfunction

    function automatic int m_lat(input logic [4:0] op, input logic [31:0] b);
        if (!m_legal(op) || m_dz(op, b)) return 1;
        if (op == 5'b01111) return MUL_LAT;
        if (op == 5'b10000) return DIV_LAT;
        return ALU_LAT;
    endfunction

    function automatic logic [63:0] m_z(input logic [4:0] op, input logic [31:0] b,
                                        input logic [63:0] r);
        if (!m_legal(op) || m_dz(op, b)) return 64'd0;
        return r;
    endfunction

    function automatic bit m_neg(input logic [4:0] op, input logic [63:0] z);
        return (op == 5'b01111) ? z[63] : z[31];
    endfunction

    function automatic bit m_hilo(input logic [4:0] op);
        return op == 5'b01111 || op == 5'b10000;
    endfunction

    // Issues one op from IDLE and returns the cycles until done rises
    task automatic do_op(input logic [4:0] op, input logic [31:0] b,
                         input logic [63:0] r, input bit poke,
                         output int lat, output int busy_n);
        int n;
        @(negedge clk);
        opcode = op;
        b_operand = b;
        alu_result = r;
        ack = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done && n < 50) begin
            if (busy) busy_n++;
            if (poke) begin
                @(negedge clk);
                start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end
        lat = n;
    endtask

    task automatic give_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        start = 1'b0;
        ack = 1'b0;
        opcode = '0;
        b_operand = '0;
        alu_result = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, valid, done, hilo_we, zero, negative, div_zero, illegal_op} !== 8'd0) begin
            $display("FAIL reset_flags got=%b want=0",
                {busy, valid, done, hilo_we, zero, negative, div_zero, illegal_op});
        end else passed++;
        total++;
        if ({z_hi, z_lo} !== 64'd0) $display("FAIL reset_z got=%h want=0", {z_hi, z_lo});
        else passed++;
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ready);
        else passed++;
    endtask

    task automatic test_add();
        int lat;
        int bn;
        do_op(5'b00011, 32'd5, 64'd12, 1'b0, lat, bn);
        total++;
        if (lat !== 1) $display("FAIL add_lat got=%0d want=1", lat); else passed++;
        total++;
        if ({z_hi, z_lo} !== 64'd12) $display("FAIL add_z got=%h want=%h", {z_hi, z_lo}, 64'd12);
        else passed++;
        total++;
        if ({hilo_we, zero, negative, valid} !== 4'b0001) begin
            $display("FAIL add_flags got=%b want=0001", {hilo_we, zero, negative, valid});
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) $display("FAIL add_done_pulse got=%b want=0", done); else passed++;
        give_ack();
        total++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL add_idle got=%b%b want=10", ready, valid);
        end else passed++;
    endtask

    task automatic test_mul();
        int lat;
        int bn;
        do_op(5'b01111, 32'd3, 64'hFFFFFFFF_FFFFFFFE, 1'b1, lat, bn);
        total++;
        if (lat !== MUL_LAT) $display("FAIL mul_lat got=%0d want=%0d", lat, MUL_LAT);
        else passed++;
        total++;
        if (bn !== MUL_LAT) $display("FAIL mul_busy got=%0d want=%0d", bn, MUL_LAT);
        else passed++;
        total++;
        if ({hilo_we, negative, zero} !== 3'b110) begin
            $display("FAIL mul_flags got=%b want=110", {hilo_we, negative, zero});
        end else passed++;
        total++;
        if ({z_hi, z_lo} !== 64'hFFFFFFFF_FFFFFFFE) $display("FAIL mul_z got=%h", {z_hi, z_lo});
        else passed++;
        give_ack();
    endtask

    task automatic test_div_zero();
        int lat;
        int bn;
        do_op(5'b10000, 32'd0, 64'h1234, 1'b0, lat, bn);
        total++;
        if (lat !== 1) $display("FAIL dz_lat got=%0d want=1", lat); else passed++;
        total++;
        if ({z_hi, z_lo} !== 64'd0) $display("FAIL dz_z got=%h want=0", {z_hi, z_lo});
        else passed++;
        total++;
        if ({div_zero, zero, hilo_we, illegal_op} !== 4'b1110) begin
            $display("FAIL dz_flags got=%b want=1110", {div_zero, zero, hilo_we, illegal_op});
        end else passed++;
        give_ack();
    endtask

    task automatic test_illegal();
        int lat;
        int bn;
        do_op(5'b11111, 32'd7, 64'hDEAD, 1'b0, lat, bn);
        total++;
        if (lat !== 1) $display("FAIL ill_lat got=%0d want=1", lat); else passed++;
        total++;
        if ({z_hi, z_lo} !== 64'd0) $display("FAIL ill_z got=%h want=0", {z_hi, z_lo});
        else passed++;
        total++;
        if ({illegal_op, hilo_we, div_zero} !== 3'b100) begin
            $display("FAIL ill_flags got=%b want=100", {illegal_op, hilo_we, div_zero});
        end else passed++;
        give_ack();
        do_op(5'b00100, 32'd1, 64'd99, 1'b0, lat, bn);
        total++;
        if (illegal_op !== 1'b0) $display("FAIL ill_clear got=%b want=0", illegal_op);
        else passed++;
        give_ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bn;
        int bad;
        logic [63:0] a;
        logic [63:0] bv;
        a  = 64'h0000_0001_8000_0000;
        bv = 64'h0000_0000_0000_0042;
        do_op(5'b00011, 32'd2, a, 1'b0, lat, bn);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1 || {z_hi, z_lo} !== a) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL hold_stable got=%0d bad cycles want=0", bad);
        else passed++;
        @(negedge clk);
        ack = 1'b1;
        start = 1'b1;
        opcode = 5'b00011;
        alu_result = bv;
        @(posedge clk);
        #1;
        ack = 1'b0;
        start = 1'b0;
        total++;
        if ({busy, valid, ready} !== 3'b100) begin
            $display("FAIL b2b_exec got=%b want=100", {busy, valid, ready});
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || {z_hi, z_lo} !== bv) begin
            $display("FAIL b2b_done got=%b/%h want=1/%h", done, {z_hi, z_lo}, bv);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        give_ack();
        @(negedge clk);
        opcode = 5'b10000;
        b_operand = 32'd3;
        alu_result = 64'h55;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        total++;
        if ({busy, valid, done, hilo_we, div_zero, z_hi, z_lo} !== '0) begin
            $display("FAIL mid_clr got=%b%b%b%b%b z=%h want=0",
                busy, valid, done, hilo_we, div_zero, {z_hi, z_lo});
        end else passed++;
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1) $display("FAIL mid_ready got=%b want=1", ready); else passed++;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || hilo_we || valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL mid_no_done got=%0d want=0", seen); else passed++;
    endtask

    task automatic test_random();
        int lat;
        int bn;
        int bad;
        logic [4:0]  op;
        logic [31:0] b;
        logic [63:0] r;
        logic [63:0] ez;
        for (int k = 0; k < 24; k++) begin
            op = 5'($urandom_range(0, 31));
            if (k % 4 == 0) op = 5'b10000;
            if (k % 4 == 1) op = 5'b01111;
            b = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            r = {$urandom, $urandom};
            ez = m_z(op, b, r);
            do_op(op, b, r, 1'b0, lat, bn);
            bad = 0;
            if (lat != m_lat(op, b)) bad++;
            if ({z_hi, z_lo} !== ez) bad++;
            if (zero !== (ez == 64'd0)) bad++;
            if (negative !== m_neg(op, ez)) bad++;
            if (hilo_we !== (m_legal(op) && m_hilo(op))) bad++;
            if (div_zero !== m_dz(op, b)) bad++;
            if (illegal_op !== !m_legal(op)) bad++;
            total++;
            if (bad != 0) begin
                $display("FAIL rand op=%b b=%h lat=%0d/%0d z=%h/%h flags=%b%b%b%b%b",
                    op, b, lat, m_lat(op, b), {z_hi, z_lo}, ez,
                    zero, negative, hilo_we, div_zero, illegal_op);
            end else passed++;
            give_ack();
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_add();
        test_mul();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
